// File: rtl/scope_trigger_capture.sv
// scope_trigger_capture
// Edge trigger with programmable pre-trigger depth. It captures a record of
// 2**pDepthBits samples into a circular RAM and then streams the record out
// over valid/ready, oldest sample first.
// Optional build macro SCOPE_AUTO_TRIG_EN adds a forced trigger after
// pAutoTrigSamples samples in WAIT_TRIG. A forced trigger leaves oTrigd low.
module scope_trigger_capture #(
`ifdef SCOPE_AUTO_TRIG_EN
  parameter int pAutoTrigSamples = 1000,
`endif
  parameter int pDepthBits = 9
) (
  input  logic                  iClk,
  input  logic                  iRst,
  input  logic [7:0]            iADC_Data,
  input  logic                  iData_Valid,
  input  logic                  iArm,
  input  logic [7:0]            iTrigLevel,
  input  logic                  iTrigRising,
  input  logic [pDepthBits-1:0] iPreTrig,
  output logic [7:0]            oRd_Data,
  output logic                  oRd_Valid,
  output logic                  oRd_Last,
  input  logic                  iRd_Ready,
  output logic                  oBusy,
  output logic                  oTrigd
);

  localparam int cDepth = 2 ** pDepthBits;
  localparam logic [pDepthBits:0]   cLastIdx  = (pDepthBits + 1)'(cDepth - 1);
  localparam logic [pDepthBits-1:0] cLastBeat = pDepthBits'(cDepth - 1);
  localparam logic [pDepthBits-1:0] cPtrOne   = pDepthBits'(1);
  localparam logic [pDepthBits:0]   cPostOne  = (pDepthBits + 1)'(1);

  typedef enum logic [2:0] {
    sIdle,
    sPre,
    sWaitTrig,
    sPost,
    sRead
  } stateT;

  stateT state;

  logic [7:0]            sampleMem [cDepth];
  logic [pDepthBits-1:0] wrPtr;
  logic [pDepthBits-1:0] rdPtr;
  logic [pDepthBits-1:0] trigAddr;
  logic [pDepthBits-1:0] preLatch;
  logic [pDepthBits-1:0] preCnt;
  logic [pDepthBits-1:0] beatCnt;
  logic [pDepthBits:0]   postCnt;
  logic [pDepthBits:0]   postTarget;
  logic [7:0]            levelLatch;
  logic [7:0]            prevSample;
  logic                  risingLatch;
  logic                  prevValid;
  logic                  storeEn;
  logic                  realTrig;
  logic                  anyTrig;

`ifdef SCOPE_AUTO_TRIG_EN
  localparam int cAutoBits = $clog2(pAutoTrigSamples + 1);
  localparam logic [cAutoBits-1:0] cAutoLast = cAutoBits'(pAutoTrigSamples - 1);
  logic [cAutoBits-1:0] autoCnt;
`endif

  // Samples are stored only while a capture is filling the buffer.
  always_comb begin
    storeEn = iData_Valid && ((state == sPre) || (state == sWaitTrig) || (state == sPost));
  end

  // The trigger sample sits at index pre, so this many samples follow it.
  always_comb begin
    postTarget = cLastIdx - {1'b0, preLatch};
  end

  // Trigger decision for the incoming sample against the previous stored one.
  always_comb begin
    realTrig = 1'b0;
    if (prevValid) begin
      if (risingLatch) begin
        realTrig = (prevSample < levelLatch) && (iADC_Data >= levelLatch);
      end else begin
        realTrig = (prevSample > levelLatch) && (iADC_Data <= levelLatch);
      end
    end
    anyTrig = realTrig;
`ifdef SCOPE_AUTO_TRIG_EN
    anyTrig = realTrig || (autoCnt == cAutoLast);
`endif
  end

  // The sample RAM has no reset, so that it maps onto block memory.
  always_ff @(posedge iClk) begin
    if (storeEn) begin
      sampleMem[wrPtr] <= iADC_Data;
    end
  end

  // Capture/readout state machine with registered outputs.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state       <= sIdle;
      wrPtr       <= '0;
      rdPtr       <= '0;
      trigAddr    <= '0;
      preLatch    <= '0;
      preCnt      <= '0;
      beatCnt     <= '0;
      postCnt     <= '0;
      levelLatch  <= '0;
      prevSample  <= '0;
      risingLatch <= 1'b0;
      prevValid   <= 1'b0;
      oRd_Data    <= '0;
      oRd_Valid   <= 1'b0;
      oRd_Last    <= 1'b0;
      oBusy       <= 1'b0;
      oTrigd      <= 1'b0;
`ifdef SCOPE_AUTO_TRIG_EN
      autoCnt     <= '0;
`endif
    end else begin
      case (state)
        sIdle: begin
          if (iArm) begin
            preLatch    <= iPreTrig;
            levelLatch  <= iTrigLevel;
            risingLatch <= iTrigRising;
            wrPtr       <= '0;
            preCnt      <= '0;
            prevValid   <= 1'b0;
            oBusy       <= 1'b1;
`ifdef SCOPE_AUTO_TRIG_EN
            autoCnt     <= '0;
`endif
            state       <= (iPreTrig == '0) ? sWaitTrig : sPre;
          end
        end

        sPre: begin
          if (iData_Valid) begin
            wrPtr      <= wrPtr + cPtrOne;
            prevSample <= iADC_Data;
            prevValid  <= 1'b1;
            preCnt     <= preCnt + cPtrOne;
            if ((preCnt + cPtrOne) == preLatch) begin
              state <= sWaitTrig;
            end
          end
        end

        sWaitTrig: begin
          if (iData_Valid) begin
            wrPtr      <= wrPtr + cPtrOne;
            prevSample <= iADC_Data;
            prevValid  <= 1'b1;
`ifdef SCOPE_AUTO_TRIG_EN
            autoCnt    <= autoCnt + 1'b1;
`endif
            if (anyTrig) begin
              trigAddr <= wrPtr;
              oTrigd   <= realTrig;
              postCnt  <= '0;
              if (postTarget == '0) begin
                rdPtr   <= wrPtr - preLatch;
                beatCnt <= '0;
                state   <= sRead;
              end else begin
                state   <= sPost;
              end
            end
          end
        end

        sPost: begin
          if (iData_Valid) begin
            wrPtr   <= wrPtr + cPtrOne;
            postCnt <= postCnt + cPostOne;
            if ((postCnt + cPostOne) == postTarget) begin
              rdPtr   <= trigAddr - preLatch;
              beatCnt <= '0;
              state   <= sRead;
            end
          end
        end

        sRead: begin
          if (!oRd_Valid) begin
            oRd_Data  <= sampleMem[rdPtr];
            rdPtr     <= rdPtr + cPtrOne;
            oRd_Valid <= 1'b1;
            oRd_Last  <= (beatCnt == cLastBeat);
          end else if (iRd_Ready) begin
            if (oRd_Last) begin
              oRd_Valid <= 1'b0;
              oRd_Last  <= 1'b0;
              oBusy     <= 1'b0;
              oTrigd    <= 1'b0;
              state     <= sIdle;
            end else begin
              oRd_Data <= sampleMem[rdPtr];
              rdPtr    <= rdPtr + cPtrOne;
              beatCnt  <= beatCnt + cPtrOne;
              oRd_Last <= ((beatCnt + cPtrOne) == cLastBeat);
            end
          end
        end

        default: state <= sIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_scope_trigger_capture.sv
// tb_scope_trigger_capture
// Drives directed and randomized captures into scope_trigger_capture
// (pDepthBits=4). A sample-stream model supplies the expected record.
// When SCOPE_AUTO_TRIG_EN is defined, the model and the DUT both use a forced
// trigger after 8 WAIT_TRIG samples.
module tb_scope_trigger_capture;

  localparam int cDepthBits = 4;
  localparam int cDepth     = 16;
  localparam int cAutoN     = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] adcData = '0;
  logic       dataValid = 1'b0;
  logic       arm = 1'b0;
  logic [7:0] trigLevel = '0;
  logic       trigRising = 1'b0;
  logic [3:0] preTrig = '0;
  logic [7:0] rdData;
  logic       rdValid;
  logic       rdLast;
  logic       rdReady = 1'b0;
  logic       busy;
  logic       trigd;

  int passCount = 0;
  int failCount = 0;
  int checkCount = 0;

  logic [7:0] stream[$];
  int         trigIdx;
  bit         trigReal;

  // 100 MHz clock.
  always #5 clk = ~clk;

  scope_trigger_capture #(
`ifdef SCOPE_AUTO_TRIG_EN
    .pAutoTrigSamples(cAutoN),
`endif
    .pDepthBits(cDepthBits)
  ) dut (
    .iClk(clk),
    .iRst(rst),
    .iADC_Data(adcData),
    .iData_Valid(dataValid),
    .iArm(arm),
    .iTrigLevel(trigLevel),
    .iTrigRising(trigRising),
    .iPreTrig(preTrig),
    .oRd_Data(rdData),
    .oRd_Valid(rdValid),
    .oRd_Last(rdLast),
    .iRd_Ready(rdReady),
    .oBusy(busy),
    .oTrigd(trigd)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // One valid strobe followed by a short random idle gap.
  task automatic applyStimulus(input logic [7:0] value);
    adcData = value;
    dataValid = 1'b1;
    @(negedge clk);
    dataValid = 1'b0;
    adcData = $urandom;
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  task automatic armCapture(input int pre, input logic [7:0] level, input bit rising, input bit withValid);
    preTrig = pre[3:0];
    trigLevel = level;
    trigRising = rising;
    arm = 1'b1;
    if (withValid) begin
      dataValid = 1'b1;
      adcData = $urandom;
    end
    @(negedge clk);
    arm = 1'b0;
    dataValid = 1'b0;
    preTrig = $urandom;
    trigLevel = ~level;
    trigRising = ~rising;
    checkOutput("armBusy", {31'd0, busy}, 32'd1);
    checkOutput("armTrigd", {31'd0, trigd}, 32'd0);
  endtask

  // Find the trigger in the stream from the trigger rules, then keep only
  // the samples the capture stores.
  task automatic analyzeStream(input int pre, input logic [7:0] level, input bit rising);
    trigIdx = -1;
    trigReal = 1'b0;
    for (int i = 0; i < stream.size() && trigIdx < 0; i++) begin
      if (i >= pre && i >= 1) begin
        if (rising ? (stream[i-1] < level && stream[i] >= level)
                   : (stream[i-1] > level && stream[i] <= level)) begin
          trigIdx = i;
          trigReal = 1'b1;
        end
      end
`ifdef SCOPE_AUTO_TRIG_EN
      if (trigIdx < 0 && i == pre + cAutoN - 1) trigIdx = i;
`endif
    end
    if (trigIdx < 0) begin
      $display("[TB] FAIL modelTrig stream has no trigger");
      $fatal(1, "[TB] stream generation error");
    end
    while (stream.size() > trigIdx + cDepth - pre) void'(stream.pop_back());
  endtask

  task automatic buildRandomStream(input int pre);
    stream.delete();
    for (int i = 0; i < pre + 42; i++) begin
      if (i < pre + 40) stream.push_back(8'($urandom));
      else stream.push_back((i % 2) ? 8'hFF : 8'h00);
    end
    for (int i = 0; i < cDepth; i++) stream.push_back(8'($urandom));
  endtask

  task automatic feedStream(input bit armInPost);
    for (int i = 0; i < stream.size(); i++) begin
      if (armInPost && i == trigIdx + 1) begin
        arm = 1'b1;
        preTrig = 4'd1;
        trigLevel = 8'h00;
        @(negedge clk);
        arm = 1'b0;
      end
      if (i == trigIdx && trigIdx > 0) checkOutput("preTrigFlag", {31'd0, trigd}, 32'd0);
      applyStimulus(stream[i]);
      if (i == trigIdx) checkOutput("trigFlag", {31'd0, trigd}, {31'd0, trigReal});
    end
  endtask

  // readyMode 0: random, 1: pattern 1,0,0 repeating, 2: always ready.
  task automatic readRecord(input int pre, input int readyMode, input bit junkInput);
    int beats = 0;
    int cyc = 0;
    int pat = 0;
    bit stalled = 1'b0;
    logic [7:0] heldData = '0;
    while (beats < cDepth && cyc < 400) begin
      if (rdValid) begin
        if (stalled) checkOutput("stallHold", {24'd0, rdData}, {24'd0, heldData});
        case (readyMode)
          0: rdReady = $urandom_range(0, 1);
          1: rdReady = (pat % 3 == 0);
          default: rdReady = 1'b1;
        endcase
        pat++;
        if (rdReady) begin
          checkOutput("beatData", {24'd0, rdData}, {24'd0, stream[trigIdx - pre + beats]});
          checkOutput("beatLast", {31'd0, rdLast}, {31'd0, beats == cDepth - 1});
          checkOutput("readTrigd", {31'd0, trigd}, {31'd0, trigReal});
          beats++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          heldData = rdData;
        end
      end else begin
        rdReady = $urandom_range(0, 1);
      end
      if (junkInput) begin
        dataValid = $urandom_range(0, 1);
        adcData = $urandom;
      end
      @(negedge clk);
      cyc++;
    end
    rdReady = 1'b0;
    dataValid = 1'b0;
    checkOutput("beatCount", beats, cDepth);
    checkOutput("endBusy", {31'd0, busy}, 32'd0);
    checkOutput("endValid", {31'd0, rdValid}, 32'd0);
    checkOutput("endTrigd", {31'd0, trigd}, 32'd0);
  endtask

  task automatic runCapture(input int pre, input logic [7:0] level, input bit rising,
                            input int readyMode, input bit armInPost, input bit junkInput);
    analyzeStream(pre, level, rising);
    armCapture(pre, level, rising, $urandom_range(0, 1));
    feedStream(armInPost);
    if (junkInput) repeat (3) applyStimulus(8'($urandom));
    readRecord(pre, readyMode, junkInput);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] simulation hung");
  end

  initial begin
    int pre;
    int waitCyc;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("rstBusy", {31'd0, busy}, 32'd0);
    checkOutput("rstValid", {31'd0, rdValid}, 32'd0);
    checkOutput("rstTrigd", {31'd0, trigd}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] rising ramp, pre=4, level=0x80");
    stream.delete();
    for (int i = 0; i < 40; i++) stream.push_back(8'((i * 16) % 256));
    runCapture(4, 8'h80, 1'b1, 2, 1'b0, 1'b0);

    $display("[TB] falling ramp, pre=4, level=0x40, arm in POST, junk in READ");
    stream.delete();
    stream.push_back(8'hFF);
    for (int i = 0; i < 40; i++) stream.push_back(8'((256 + 240 - 16 * i) % 256));
    runCapture(4, 8'h40, 1'b0, 1, 1'b1, 1'b1);

    $display("[TB] randomized captures");
    for (int n = 0; n < 8; n++) begin
      pre = (n == 0) ? 0 : (n == 1) ? cDepth - 1 : $urandom_range(0, cDepth - 1);
      buildRandomStream(pre);
      runCapture(pre, 8'($urandom_range(1, 254)), $urandom_range(0, 1),
                 $urandom_range(0, 2), (pre < cDepth - 2), 1'b0);
    end

    $display("[TB] reset during readout");
    pre = $urandom_range(0, cDepth - 1);
    buildRandomStream(pre);
    analyzeStream(pre, 8'h80, 1'b1);
    armCapture(pre, 8'h80, 1'b1, 1'b0);
    feedStream(1'b0);
    waitCyc = 0;
    while (!rdValid && waitCyc < 50) begin
      @(negedge clk);
      waitCyc++;
    end
    checkOutput("readStart", {31'd0, rdValid}, 32'd1);
    rdReady = 1'b1;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("midRstBusy", {31'd0, busy}, 32'd0);
    checkOutput("midRstValid", {31'd0, rdValid}, 32'd0);
    checkOutput("midRstLast", {31'd0, rdLast}, 32'd0);
    checkOutput("midRstTrigd", {31'd0, trigd}, 32'd0);
    rdReady = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    buildRandomStream(6);
    runCapture(6, 8'h55, 1'b0, 0, 1'b0, 1'b0);

`ifdef SCOPE_AUTO_TRIG_EN
    $display("[TB] forced trigger on constant input");
    stream.delete();
    for (int i = 0; i < 40; i++) stream.push_back(8'h10);
    runCapture(4, 8'h80, 1'b1, 2, 1'b0, 1'b0);
`endif

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/scope_trigger_capture.md
Name: scope_trigger_capture

Overview:
- Sits directly downstream of the ADC interface stage and consumes its 8-bit sample stream (one-cycle valid strobe, 10 MS/s inside the 100 MHz domain).
- Implements a level/edge trigger with programmable pre-trigger depth and captures a fixed-length record into a circular sample RAM.
- Streams the record out, oldest sample first, over a valid/ready interface toward the host link.

Parameters:
- pDepthBits, 9, log2 of record length; DEPTH = 2**pDepthBits samples.
- pAutoTrigSamples, 1000, samples spent in WAIT_TRIG before a forced trigger (used only with the optional feature).

Ports:
- iClk  input  1  100 MHz system clock.
- iRst  input  1  asynchronous, active-high reset.
- iADC_Data  input  8  sample from the ADC stage.
- iData_Valid  input  1  one-cycle strobe qualifying iADC_Data.
- iArm  input  1  pulse that starts a capture; honoured only in IDLE.
- iTrigLevel  input  8  trigger threshold, unsigned.
- iTrigRising  input  1  1 = rising-edge trigger, 0 = falling-edge trigger.
- iPreTrig  input  pDepthBits  samples to retain before the trigger; latched on arm.
- oRd_Data  output  8  readout sample.
- oRd_Valid  output  1  oRd_Data is valid.
- oRd_Last  output  1  marks the final sample of the record, qualified by oRd_Valid.
- iRd_Ready  input  1  downstream accepts the sample.
- oBusy  output  1  high from accepted arm until the last readout beat is accepted.
- oTrigd  output  1  high from the trigger event until return to IDLE.

Behaviour:
- Reset (async, iRst=1) puts the state machine in IDLE. Pointers and counters reset to 0. All outputs reset to 0.
- States:
  - IDLE: iArm=1 -> PRE. Latch iPreTrig, iTrigLevel and iTrigRising. Clear the write pointer, sample counter and prev-valid flag.
  - PRE: each valid sample is written at wptr; wptr increments mod DEPTH. When the count reaches the latched pre value, go to WAIT_TRIG. A pre value of 0 enters WAIT_TRIG on the cycle after arm.
  - WAIT_TRIG: writing continues circularly. On a valid sample, evaluate the trigger.
    - Rising trigger: prev < level and cur >= level.
    - Falling trigger: prev > level and cur <= level.
    - prev is the previous valid sample of this capture. No trigger is possible until one sample has been stored (prev-valid flag).
    - On trigger, record trig_addr = wptr of the triggering sample, set oTrigd, and go to POST.
  - POST: store DEPTH-1-pre further samples, then go to READ. The trigger sample sits at record index pre.
  - READ: raddr starts at trig_addr - pre (mod DEPTH). Emit DEPTH samples.
- Pre-trigger wrap: triggers in WAIT_TRIG are legal before DEPTH samples are written. Record entries older than the first write then hold stale RAM data. This is documented behaviour, not an error.
- Readout handshake:
  - RAM read latency is 1 cycle; oRd_Valid rises 1 cycle after entering READ.
  - A beat transfers when oRd_Valid and iRd_Ready are both high.
  - oRd_Data, oRd_Valid and oRd_Last stay stable while iRd_Ready=0.
  - The next RAM read is issued on the transfer cycle, so back-to-back transfers run at 1 per cycle.
  - oRd_Last is high on beat DEPTH-1. After that beat is accepted, clear oBusy, oTrigd and oRd_Valid and go to IDLE.
- iData_Valid is ignored in IDLE and READ; samples arriving then are dropped.
- iArm outside IDLE is ignored.
- iArm and iData_Valid in the same IDLE cycle: that sample is not stored; capture begins with the next valid sample.
- A pre value of DEPTH-1 is legal (trigger is the last record sample, POST stores 0 samples).
- iRst mid-capture or mid-readout aborts immediately to IDLE with all outputs 0. RAM contents are undefined afterwards.
- Counter widths: the pre counter is pDepthBits. The POST counter is pDepthBits+1 and wraps nowhere. All pointer arithmetic is mod DEPTH.

Optional Feature:
- Macro SCOPE_AUTO_TRIG_EN.
- Defined: WAIT_TRIG counts valid samples. When the count reaches pAutoTrigSamples without a real trigger, the current sample is a forced trigger and proceeds exactly as a real trigger. Only the real-trigger path sets oTrigd; a forced trigger leaves oTrigd=0 so software can distinguish.
- Undefined: no counter is present and WAIT_TRIG waits indefinitely.

Test Plan (pDepthBits=4, DEPTH=16):
- Reset mid-READ -> on the same cycle oBusy, oRd_Valid, oRd_Last and oTrigd read 0; a new iArm is accepted afterwards.
- Arm with pre=4, level=0x80, rising; feed a ramp 0x00,0x10,...,0xF0,... -> trigger at 0x80. Readout is 16 beats 0x40..0xF0,0x00..0x30, oRd_Last on beat 16, oTrigd=1, then IDLE.
- Same setup, falling, level=0x40; feed 0xFF then a ramp down in steps of 0x10 -> trigger at 0x40, and record index 4 holds 0x40.
- Readout with iRd_Ready toggling 1,0,0,1,... -> no beat dropped or duplicated; data held steady during stalls; exactly 16 transfers.
- iArm pulsed during POST, and iData_Valid during READ -> both ignored; record contents unchanged.
- SCOPE_AUTO_TRIG_EN, pAutoTrigSamples=8, constant input 0x10 -> forced trigger after 8 WAIT_TRIG samples, oTrigd=0, full 16-beat readout of 0x10.
